// File: rtl/wave_pkg.sv
// Shared definitions for the sample-path serial links: sample width,
// serializer state encoding and the two's-complement to offset-binary map.
package wave_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Offset-binary is two's-complement with the sign bit inverted, so the
  // most negative code lands on all-zeros and the most positive on all-ones.
  function automatic logic [SAMPLE_W-1:0] to_offset_binary(
    input logic signed [SAMPLE_W-1:0] s
  );
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/dac_sample_serializer_sclk_tick_gen.sv
// Free-running divider producing a one-clk tick every CLK_DIV clks; the
// serial link uses each tick as a half-period boundary of its bit clock.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == CW'(CLK_DIV - 1));

  // Wrap on the terminal count; a clear restarts the phase so a new frame
  // always begins with a full half-period.
  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  // Divider count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dac_sample_serializer.sv
// Final stage of the sample path: accepts one signed sample per frame via
// valid/ready, converts it to offset-binary and shifts it MSB-first to a
// 3-wire serial DAC (sclk idle low, data sampled by the DAC on sclk rise).
module dac_sample_serializer
  import wave_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     dac_sclk,
  output logic                     dac_mosi,
  output logic                     dac_cs_n,
  output logic                     busy
);

  localparam int BW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              tick;
  logic [DATA_W-1:0] sample_ob;

  assign accept = sample_valid && ready_q;

  if (DATA_W == SAMPLE_W) begin : g_ob_pkg
    assign sample_ob = to_offset_binary(sample);
  end else begin : g_ob_generic
    assign sample_ob = {~sample[DATA_W-1], sample[DATA_W-2:0]};
  end

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  // Frame sequencing. In SHIFT a tick with sclk high is a falling edge
  // (advance to the next bit); a tick with sclk low is a rising edge unless
  // all DATA_W bits have already been clocked out, in which case that
  // half-period closes the frame instead of starting another bit.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SETUP;
          shreg_d   = sample_ob;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          mosi_d    = sample_ob[DATA_W-1];
          cs_n_d    = 1'b0;
        end
      end
      SETUP: begin
        mosi_d = shreg_q[DATA_W-1];
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d    = 1'b0;
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            mosi_d    = shreg_q[DATA_W-2];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (bit_cnt_q == BW'(DATA_W)) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
            cs_n_d  = 1'b1;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and registered link outputs; the shift register holds data only
  // and is always overwritten on acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign sample_ready = ready_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign dac_cs_n     = cs_n_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dac_sample_serializer.sv
// Bench for dac_sample_serializer: three instances (CLK_DIV 4, 2, 1), a
// DAC-side capture monitor, and an expected-word queue filled at acceptance.
module tb_dac_sample_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] smp  [3];
  logic        vld  [3];
  logic        rdy  [3];
  logic        sclk [3];
  logic        mosi [3];
  logic        csn  [3];
  logic        bsy  [3];

  int sel    = 0;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] exp_q[$];

  // capture monitor state (written only by the monitor)
  int          frames      = 0;
  int          rise_total  = 0;
  int          stray_total = 0;
  int          viol_total  = 0;
  logic [15:0] word_a  [64];
  int          nbits_a [64];
  int          fall_t  [64];
  int          rise_t  [64];
  int          r1_t    [64];
  int          r2_t    [64];
  logic [15:0] cur_word = 16'h0;
  int          cur_n    = 0;
  logic        p_sclk   = 1'b0;
  logic        p_csn    = 1'b1;
  logic        p_mosi   = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    dac_sample_serializer #(
      .DATA_W (16),
      .CLK_DIV(D)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .sample      (smp[g]),
      .sample_valid(vld[g]),
      .sample_ready(rdy[g]),
      .dac_sclk    (sclk[g]),
      .dac_mosi    (mosi[g]),
      .dac_cs_n    (csn[g]),
      .busy        (bsy[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behaves like the DAC: shifts mosi in on each sclk rise inside a frame.
  always @(negedge clk) begin
    logic s, c, m;
    s = sclk[sel];
    c = csn[sel];
    m = mosi[sel];
    if (c === 1'b0 && p_csn === 1'b1) begin
      cur_word       = 16'h0;
      cur_n          = 0;
      fall_t[frames] = cyc;
    end
    if (s === 1'b1 && p_sclk === 1'b0) begin
      rise_total++;
      if (c === 1'b0) begin
        if (m !== p_mosi) viol_total++;
        cur_word = {cur_word[14:0], m};
        cur_n++;
        if (cur_n == 1) r1_t[frames] = cyc;
        if (cur_n == 2) r2_t[frames] = cyc;
      end else begin
        stray_total++;
      end
    end else if (s === 1'b1 && p_sclk === 1'b1 && m !== p_mosi) begin
      viol_total++;
    end
    if (c === 1'b1 && p_csn === 1'b0) begin
      word_a[frames]  = cur_word;
      nbits_a[frames] = cur_n;
      rise_t[frames]  = cyc;
      if (frames < 63) frames++;
    end
    p_sclk = s;
    p_csn  = c;
    p_mosi = m;
  end

  function automatic logic [15:0] ob(input logic [15:0] s);
    return s ^ 16'h8000;
  endfunction

  // Offers a sample until it is taken; acc is the index of the accepting edge.
  task automatic send(input logic [15:0] s, input bit hold, output int acc, output bit to);
    int n;
    n   = 0;
    acc = 0;
    to  = 1'b0;
    smp[sel] = s;
    vld[sel] = 1'b1;
    @(negedge clk);
    while (rdy[sel] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      to       = 1'b1;
      vld[sel] = 1'b0;
    end else begin
      exp_q.push_back(ob(s));
      acc = cyc + 1;
      @(posedge clk);
      #1;
      if (!hold) vld[sel] = 1'b0;
    end
  endtask

  task automatic wait_ready(output int rc, output bit to);
    int n;
    n  = 0;
    rc = 0;
    to = 1'b0;
    @(negedge clk);
    while (rdy[sel] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) to = 1'b1;
    rc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (sclk[i] !== 1'b0) begin errors++; $display("FAIL reset_sclk[%0d]: got %b want 0", i, sclk[i]); end
      checks++; if (mosi[i] !== 1'b0) begin errors++; $display("FAIL reset_mosi[%0d]: got %b want 0", i, mosi[i]); end
      checks++; if (csn[i] !== 1'b1) begin errors++; $display("FAIL reset_csn[%0d]: got %b want 1", i, csn[i]); end
      checks++; if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bsy[i]); end
      checks++; if (rdy[i] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", i, rdy[i]); end
    end
    // valid during reset must not be accepted
    smp[0] = 16'h1234;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    vld[0] = 1'b0;
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL rst_valid_busy: got %b want 0", bsy[0]); end
    checks++; if (csn[0] !== 1'b1) begin errors++; $display("FAIL rst_valid_csn: got %b want 1", csn[0]); end
    @(posedge clk);
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rst_valid_ready: got %b want 1", rdy[0]); end
  endtask

  task automatic test_basic_div2();
    int acc, rc, f0, r0;
    bit to1, to2;
    logic [15:0] e;
    sel = 1;
    f0  = frames;
    r0  = rise_total;
    send(16'h0000, 1'b0, acc, to1);
    wait_ready(rc, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL div2_timeout: got %b%b want 00", to1, to2); end
    checks++; if (rc - acc != 68) begin errors++; $display("FAIL div2_ready_lat: got %0d want 68", rc - acc); end
    checks++; if (frames != f0 + 1) begin errors++; $display("FAIL div2_frames: got %0d want %0d", frames, f0 + 1); end
    e = 16'hxxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++; if (word_a[f0] !== e) begin errors++; $display("FAIL div2_word: got %h want %h", word_a[f0], e); end
    checks++; if (nbits_a[f0] != 16) begin errors++; $display("FAIL div2_nbits: got %0d want 16", nbits_a[f0]); end
    checks++; if (rise_total - r0 != 16) begin errors++; $display("FAIL div2_rises: got %0d want 16", rise_total - r0); end
    checks++; if (rise_t[f0] - fall_t[f0] != 66) begin errors++; $display("FAIL div2_csn_low: got %0d want 66", rise_t[f0] - fall_t[f0]); end
    checks++; if (fall_t[f0] != acc) begin errors++; $display("FAIL div2_csn_fall: got %0d want %0d", fall_t[f0], acc); end
    checks++; if (r2_t[f0] - r1_t[f0] != 4) begin errors++; $display("FAIL div2_sclk_period: got %0d want 4", r2_t[f0] - r1_t[f0]); end
  endtask

  task automatic test_mapping();
    logic [15:0] vals [3];
    int acc, rc, f0;
    bit to1, to2;
    logic [15:0] e;
    vals = '{16'h8000, 16'hFFFF, 16'h7FFF};
    sel  = 0;
    for (int k = 0; k < 3; k++) begin
      f0 = frames;
      send(vals[k], 1'b0, acc, to1);
      wait_ready(rc, to2);
      checks++; if (to1 || to2) begin errors++; $display("FAIL map_timeout[%0d]: got %b%b want 00", k, to1, to2); end
      if (k == 0) begin
        checks++; if (rc - acc != 136) begin errors++; $display("FAIL map_ready_lat: got %0d want 136", rc - acc); end
      end
      e = 16'hxxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++; if (word_a[f0] !== e) begin errors++; $display("FAIL map_word[%0d]: got %h want %h", k, word_a[f0], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    int acc [4];
    int rc, f0;
    bit to, any_to;
    logic [15:0] e;
    vals   = '{16'h0001, 16'hA5C3, 16'h7F00, 16'h8001};
    sel    = 0;
    f0     = frames;
    any_to = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(vals[k], (k < 3), acc[k], to);
      any_to |= to;
    end
    wait_ready(rc, to);
    any_to |= to;
    checks++; if (any_to) begin errors++; $display("FAIL b2b_timeout: got 1 want 0"); end
    checks++; if (frames != f0 + 4) begin errors++; $display("FAIL b2b_frames: got %0d want %0d", frames, f0 + 4); end
    for (int k = 0; k < 4; k++) begin
      e = 16'hxxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++; if (word_a[f0 + k] !== e) begin errors++; $display("FAIL b2b_word[%0d]: got %h want %h", k, word_a[f0 + k], e); end
    end
    for (int k = 1; k < 4; k++) begin
      checks++; if (acc[k] - acc[k-1] != 137) begin errors++; $display("FAIL b2b_period[%0d]: got %0d want 137", k, acc[k] - acc[k-1]); end
      checks++; if (fall_t[f0 + k] - rise_t[f0 + k - 1] != 5) begin errors++; $display("FAIL b2b_csn_high[%0d]: got %0d want 5", k, fall_t[f0 + k] - rise_t[f0 + k - 1]); end
    end
    repeat (300) @(posedge clk);
    #1;
    checks++; if (frames != f0 + 4) begin errors++; $display("FAIL b2b_extra_frames: got %0d want %0d", frames, f0 + 4); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", bsy[0]); end
  endtask

  task automatic test_change_while_busy();
    int acc_a, acc_b, rc, f0;
    bit to1, to2, to3;
    logic [15:0] e;
    sel = 0;
    f0  = frames;
    send(16'h1111, 1'b1, acc_a, to1);
    repeat (20) @(posedge clk);
    #1;
    smp[0] = 16'h2222;
    repeat (20) @(posedge clk);
    #1;
    send(16'h4321, 1'b0, acc_b, to2);
    wait_ready(rc, to3);
    checks++; if (to1 || to2 || to3) begin errors++; $display("FAIL chg_timeout: got %b%b%b want 000", to1, to2, to3); end
    checks++; if (frames != f0 + 2) begin errors++; $display("FAIL chg_frames: got %0d want %0d", frames, f0 + 2); end
    checks++; if (acc_b - acc_a != 137) begin errors++; $display("FAIL chg_period: got %0d want 137", acc_b - acc_a); end
    for (int k = 0; k < 2; k++) begin
      e = 16'hxxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++; if (word_a[f0 + k] !== e) begin errors++; $display("FAIL chg_word[%0d]: got %h want %h", k, word_a[f0 + k], e); end
    end
  endtask

  task automatic test_div1();
    int acc, rc, f0;
    bit to1, to2;
    logic [15:0] e;
    sel = 2;
    f0  = frames;
    send(16'h1234, 1'b0, acc, to1);
    wait_ready(rc, to2);
    checks++; if (to1 || to2) begin errors++; $display("FAIL div1_timeout: got %b%b want 00", to1, to2); end
    checks++; if (rc - acc != 34) begin errors++; $display("FAIL div1_ready_lat: got %0d want 34", rc - acc); end
    e = 16'hxxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++; if (word_a[f0] !== e) begin errors++; $display("FAIL div1_word: got %h want %h", word_a[f0], e); end
    checks++; if (r2_t[f0] - r1_t[f0] != 2) begin errors++; $display("FAIL div1_sclk_period: got %0d want 2", r2_t[f0] - r1_t[f0]); end
    checks++; if (rise_t[f0] - fall_t[f0] != 33) begin errors++; $display("FAIL div1_csn_low: got %0d want 33", rise_t[f0] - fall_t[f0]); end
  endtask

  task automatic test_reset_mid_shift();
    int acc, f0, r0;
    bit to;
    logic [15:0] e;
    sel = 0;
    f0  = frames;
    send(16'h5A5A, 1'b0, acc, to);
    repeat (40) @(posedge clk);
    #1;
    r0  = rise_total;
    checks++; if (to || bsy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", bsy[0]); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (csn[0] !== 1'b1) begin errors++; $display("FAIL rstmid_csn: got %b want 1", csn[0]); end
    checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b want 0", sclk[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", rdy[0]); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bsy[0]); end
    checks++; if (mosi[0] !== 1'b0) begin errors++; $display("FAIL rstmid_mosi: got %b want 0", mosi[0]); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++; if (rise_total != r0) begin errors++; $display("FAIL rstmid_no_edges: got %0d want %0d", rise_total - r0, 0); end
    checks++; if (frames != f0 + 1) begin errors++; $display("FAIL rstmid_frames: got %0d want %0d", frames, f0 + 1); end
    checks++; if (nbits_a[f0] >= 16) begin errors++; $display("FAIL rstmid_partial: got %0d bits want fewer than 16", nbits_a[f0]); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle: got %b want 0", bsy[0]); end
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  task automatic test_link_integrity();
    checks++; if (stray_total != 0) begin errors++; $display("FAIL sclk_outside_frame: got %0d want 0", stray_total); end
    checks++; if (viol_total != 0) begin errors++; $display("FAIL mosi_stability: got %0d want 0", viol_total); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      smp[i] = 16'h0;
      vld[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic_div2();
    test_mapping();
    test_back_to_back();
    test_change_while_busy();
    test_div1();
    test_reset_mid_shift();
    test_link_integrity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
